fft_frame_ctrl: RTL and testbench

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Frame sequencer between a streaming sample source, an FFT core and a
// result sink. It loads N_PT samples into the core, waits for the core to
// answer (with a cycle timeout), and drains N_PT results through a
// valid/ready output stage. Protocol violations are flagged in sticky
// error bits, and completed frames are counted.

module fft_frame_ctrl #(
    parameter int unsigned N_PT    = 128,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_enable,
    input  logic              cfg_abort,
    input  logic              cfg_err_clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              fft_start,
    output logic              fft_valid,
    output logic [DATA_W-1:0] fft_data,
    input  logic              fft_out_valid,
    input  logic [DATA_W-1:0] fft_out_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              frame_done,
    output logic              err_len,
    output logic              err_timeout,
    output logic              err_overflow,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned CNT_W  = (N_PT > 1) ? $clog2(N_PT) : 1;
    localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_in_cnt;
    logic [CNT_W-1:0]    r_out_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_fft_start;
    logic                r_fft_valid;
    logic [DATA_W-1:0]   r_fft_data;
    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_last;
    logic                r_frame_done;
    logic [15:0]         r_frame_cnt;
    logic                r_err_len;
    logic                r_err_timeout;
    logic                r_err_overflow;

    logic w_s_accept;
    logic w_m_pop;
    logic w_in_last;
    logic w_out_last;
    logic w_res_window;
    logic w_res_take;
    logic w_res_drop;
    logic w_res_load;
    logic w_timeout_hit;
    logic w_len_err;
    logic w_ovf_err;
    logic w_to_err;

    // Handshake and event decode shared by the sequencer and the error logic
    always_comb begin
        w_s_accept    = s_valid && (r_state == S_LOAD);
        w_m_pop       = r_m_valid && m_ready;
        w_in_last     = (r_in_cnt == CNT_W'(N_PT - 1));
        w_out_last    = (r_out_cnt == CNT_W'(N_PT - 1));
        w_res_window  = (r_state == S_WAIT) || (r_state == S_DRAIN);
        w_res_take    = fft_out_valid && w_res_window;
        w_res_drop    = w_res_take && r_m_valid && !m_ready;
        w_res_load    = w_res_take && !w_res_drop;
        w_timeout_hit = (r_state == S_WAIT) && !fft_out_valid &&
                        (r_wait_cnt == WAIT_W'(TIMEOUT));
        w_len_err     = w_s_accept && (s_last != w_in_last);
        w_ovf_err     = (fft_out_valid && !w_res_window) || w_res_drop;
        w_to_err      = w_timeout_hit;
    end

    // Frame sequencer with registered datapath outputs; abort overrides all
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_fft_start  <= 1'b0;
            r_fft_valid  <= 1'b0;
            r_fft_data   <= '0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_last     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_fft_start  <= 1'b0;
            r_frame_done <= 1'b0;
            r_fft_valid  <= w_s_accept;
            if (w_s_accept) begin
                r_fft_data <= s_data;
            end

            // Output stage: a new result replaces the held one only when the
            // slot is free or being emptied this cycle; otherwise it is dropped.
            if (w_res_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= fft_out_data;
                r_m_last  <= w_out_last;
            end else if (w_m_pop) begin
                r_m_valid <= 1'b0;
            end

            if (cfg_abort) begin
                r_state     <= S_IDLE;
                r_in_cnt    <= '0;
                r_out_cnt   <= '0;
                r_wait_cnt  <= '0;
                r_m_valid   <= 1'b0;
                r_fft_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cfg_enable) begin
                            r_state     <= S_LOAD;
                            r_fft_start <= 1'b1;
                            r_in_cnt    <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (w_s_accept) begin
                            if (w_in_last) begin
                                r_in_cnt   <= '0;
                                r_wait_cnt <= '0;
                                r_state    <= S_WAIT;
                            end else begin
                                r_in_cnt <= r_in_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_WAIT, S_DRAIN: begin
                        // Dropped results still count toward the frame length.
                        if (w_res_take) begin
                            if (w_out_last) begin
                                r_out_cnt    <= '0;
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                                r_frame_cnt  <= r_frame_cnt + 16'd1;
                            end else begin
                                r_out_cnt <= r_out_cnt + CNT_W'(1);
                                r_state   <= S_DRAIN;
                            end
                            r_wait_cnt <= '0;
                        end else if (w_timeout_hit) begin
                            r_wait_cnt <= '0;
                            r_state    <= S_IDLE;
                        end else if (r_state == S_WAIT) begin
                            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky errors: a newly detected error wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_len      <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_err_len      <= (r_err_len      && !cfg_err_clr) || (w_len_err && !cfg_abort);
            r_err_timeout  <= (r_err_timeout  && !cfg_err_clr) || (w_to_err  && !cfg_abort);
            r_err_overflow <= (r_err_overflow && !cfg_err_clr) || (w_ovf_err && !cfg_abort);
        end
    end

    assign s_ready      = (r_state == S_LOAD);
    assign busy         = (r_state != S_IDLE);
    assign fft_start    = r_fft_start;
    assign fft_valid    = r_fft_valid;
    assign fft_data     = r_fft_data;
    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign m_last       = r_m_last;
    assign frame_done   = r_frame_done;
    assign frame_cnt    = r_frame_cnt;
    assign err_len      = r_err_len;
    assign err_timeout  = r_err_timeout;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Testbench for fft_frame_ctrl: directed frames with a scoreboard for the
// core-side sample stream and the result stream.

module tb_fft_frame_ctrl;

    localparam int N = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_enable;
    logic        cfg_abort;
    logic        cfg_err_clr;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        fft_start;
    logic        fft_valid;
    logic [31:0] fft_data;
    logic        fft_out_valid;
    logic [31:0] fft_out_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        frame_done;
    logic        err_len;
    logic        err_timeout;
    logic        err_overflow;
    logic [15:0] frame_cnt;

    fft_frame_ctrl #(
        .N_PT    (N),
        .DATA_W  (32),
        .TIMEOUT (1023)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_enable    (cfg_enable),
        .cfg_abort     (cfg_abort),
        .cfg_err_clr   (cfg_err_clr),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .fft_start     (fft_start),
        .fft_valid     (fft_valid),
        .fft_data      (fft_data),
        .fft_out_valid (fft_out_valid),
        .fft_out_data  (fft_out_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .err_overflow  (err_overflow),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int idle_cycles = 0;

    logic [31:0] q_fft[$];
    logic [32:0] q_m[$];
    logic [31:0] e_fft;
    logic [32:0] e_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected values whenever the DUT presents output
    always @(negedge clk) begin
        if (!reset) begin
            if (fft_valid) begin
                n_tests++;
                if (q_fft.size() == 0) begin
                    n_fail++;
                    $display("FAIL fft_valid_unexpected: got data 0x%0h, expected no sample (t=%0t)", fft_data, $time);
                end else begin
                    e_fft = q_fft.pop_front();
                    if (fft_data !== e_fft) begin
                        n_fail++;
                        $display("FAIL fft_data: got 0x%0h, expected 0x%0h (t=%0t)", fft_data, e_fft, $time);
                    end
                end
            end
            if (m_valid && m_ready) begin
                n_tests++;
                if (q_m.size() == 0) begin
                    n_fail++;
                    $display("FAIL m_unexpected: got data 0x%0h, expected no result (t=%0t)", m_data, $time);
                end else begin
                    e_m = q_m.pop_front();
                    if ({m_last, m_data} !== e_m) begin
                        n_fail++;
                        $display("FAIL m_result: got last=%0b data=0x%0h, expected last=%0b data=0x%0h (t=%0t)",
                                 m_last, m_data, e_m[32], e_m[31:0], $time);
                    end
                end
            end
            if (fft_start)  start_cnt++;
            if (frame_done) done_cnt++;
            if (!busy)      idle_cycles++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] res_word(input int frame_id, input int k);
        return {8'(frame_id), 8'hA5, 16'(k)};
    endfunction

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic send_sample(input logic [31:0] d, input logic last, input logic clr);
        int w;
        w = 0;
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        cfg_err_clr = clr;
        @(negedge clk);
        while (!s_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        n_tests++;
        if (!s_ready) begin
            n_fail++;
            $display("FAIL s_ready_wait: got s_ready=0 after %0d cycles, expected 1", w);
        end else begin
            q_fft.push_back(d);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
        cfg_err_clr = 1'b0;
    endtask

    task automatic load_frame(input int last_idx, input int count, input logic keep_en, input logic clr_at_end);
        cfg_enable = 1'b1;
        for (int i = 0; i < count; i++) begin
            send_sample(32'(i), (i == last_idx), clr_at_end && (i == N - 1));
            if (i == 0 && !keep_en) cfg_enable = 1'b0;
        end
    endtask

    task automatic core_results(input int frame_id, input logic all_taken);
        for (int k = 0; k < N; k++) begin
            fft_out_valid = 1'b1;
            fft_out_data = res_word(frame_id, k);
            if (all_taken || k == 0)
                q_m.push_back({(all_taken && k == N - 1), res_word(frame_id, k)});
            @(posedge clk);
            #1;
        end
        fft_out_valid = 1'b0;
        fft_out_data = '0;
    endtask

    task automatic err_clr_pulse();
        cfg_err_clr = 1'b1;
        @(posedge clk);
        #1;
        cfg_err_clr = 1'b0;
    endtask

    int d0;
    int s0;
    int n;

    initial begin
        reset = 1'b1;
        cfg_enable = 1'b0;
        cfg_abort = 1'b1;
        cfg_err_clr = 1'b0;
        s_valid = 1'b1;
        s_data = 32'hDEAD_BEEF;
        s_last = 1'b1;
        fft_out_valid = 1'b0;
        fft_out_data = '0;
        m_ready = 1'b1;
        settle(3);
        check("rst_busy",      32'(busy), 0);
        check("rst_s_ready",   32'(s_ready), 0);
        check("rst_fft_valid", 32'(fft_valid), 0);
        check("rst_fft_data",  fft_data, 0);
        check("rst_m_valid",   32'(m_valid), 0);
        check("rst_m_data",    m_data, 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_errs",      32'({err_len, err_timeout, err_overflow}), 0);
        reset = 1'b0;
        cfg_abort = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        settle(2);

        // Nominal frame
        d0 = done_cnt; s0 = start_cnt;
        load_frame(N - 1, N, 1'b0, 1'b0);
        core_results(1, 1'b1);
        check("nom_done_state", 32'(frame_done), 1);
        settle(3);
        check("nom_start_pulses", 32'(start_cnt - s0), 1);
        check("nom_done_pulses",  32'(done_cnt - d0), 1);
        check("nom_frame_cnt",    32'(frame_cnt), 1);
        check("nom_errs",         32'({err_len, err_timeout, err_overflow}), 0);
        check("nom_fft_q_empty",  32'(q_fft.size()), 0);
        check("nom_m_q_empty",    32'(q_m.size()), 0);
        check("nom_busy",         32'(busy), 0);

        // Early s_last plus missing final s_last; clear on the erroring cycle loses
        d0 = done_cnt;
        load_frame(63, N, 1'b0, 1'b1);
        check("len_err_set", 32'(err_len), 1);
        core_results(2, 1'b1);
        settle(3);
        check("len_frame_cnt",   32'(frame_cnt), 2);
        check("len_done_pulses", 32'(done_cnt - d0), 1);
        check("len_m_q_empty",   32'(q_m.size()), 0);
        err_clr_pulse();
        check("len_err_clr", 32'(err_len), 0);

        // Timeout: core stays silent
        d0 = done_cnt;
        load_frame(N - 1, N, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        check("to_cycles",    32'(n), 1025);
        check("to_err",       32'(err_timeout), 1);
        check("to_frame_cnt", 32'(frame_cnt), 2);
        check("to_no_done",   32'(done_cnt - d0), 0);
        @(posedge clk); #1;
        err_clr_pulse();
        check("to_err_clr", 32'(err_timeout), 0);

        // Backpressure: sink stalls for the whole drain
        d0 = done_cnt;
        m_ready = 1'b0;
        load_frame(N - 1, N, 1'b0, 1'b0);
        core_results(3, 1'b0);
        settle(2);
        check("bp_done_pulses", 32'(done_cnt - d0), 1);
        check("bp_overflow",    32'(err_overflow), 1);
        check("bp_m_valid",     32'(m_valid), 1);
        check("bp_m_data",      m_data, res_word(3, 0));
        check("bp_m_last",      32'(m_last), 0);
        check("bp_frame_cnt",   32'(frame_cnt), 3);
        m_ready = 1'b1;
        settle(2);
        check("bp_m_q_empty", 32'(q_m.size()), 0);
        check("bp_m_drained", 32'(m_valid), 0);
        err_clr_pulse();
        check("bp_err_clr", 32'(err_overflow), 0);

        // Abort with in_cnt=50, then a clean frame
        d0 = done_cnt;
        load_frame(N - 1, 50, 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data = 32'd50;
        cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        s_valid = 1'b0;
        check("ab_busy",      32'(busy), 0);
        check("ab_s_ready",   32'(s_ready), 0);
        check("ab_fft_valid", 32'(fft_valid), 0);
        settle(3);
        check("ab_no_done",   32'(done_cnt - d0), 0);
        check("ab_fft_q",     32'(q_fft.size()), 0);
        load_frame(N - 1, N, 1'b0, 1'b0);
        core_results(4, 1'b1);
        settle(3);
        check("ab_next_done", 32'(done_cnt - d0), 1);
        check("ab_frame_cnt", 32'(frame_cnt), 4);
        check("ab_errs",      32'({err_len, err_timeout, err_overflow}), 0);

        // Back-to-back with enable held
        d0 = done_cnt; s0 = start_cnt;
        for (int f = 0; f < 3; f++) begin
            load_frame(N - 1, N, 1'b1, 1'b0);
            if (f == 0) idle_cycles = 0;
            core_results(5 + f, 1'b1);
        end
        cfg_enable = 1'b0;
        check("b2b_idle_gaps", 32'(idle_cycles), 2);
        settle(3);
        check("b2b_done_pulses",  32'(done_cnt - d0), 3);
        check("b2b_start_pulses", 32'(start_cnt - s0), 3);
        check("b2b_frame_cnt",    32'(frame_cnt), 7);
        check("b2b_m_q_empty",    32'(q_m.size()), 0);

        // Frame counter wrap
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        @(negedge clk);
        check("wrap_preload", 32'(frame_cnt), 32'hFFFF);
        @(posedge clk); #1;
        load_frame(N - 1, N, 1'b0, 1'b0);
        core_results(9, 1'b1);
        settle(3);
        check("wrap_frame_cnt", 32'(frame_cnt), 0);
        check("wrap_errs",      32'({err_len, err_timeout, err_overflow}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
